// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states
// and the shadow-stage tag records that track the datapath's pipeline registers.
package hazard_pkg;

    // Tags are stored at a fixed width wide enough for any supported register file.
    localparam int HZ_TAG_W = 8;

    typedef logic [HZ_TAG_W-1:0] tag_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_STALL  = 2'd1,
        HZ_FREEZE = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic v;
        tag_t rd;
        tag_t rs1;
        tag_t rs2;
        logic wen;
        logic load;
    } ex_stage_t;

    typedef struct packed {
        logic v;
        tag_t rd;
        logic wen;
        logic load;
    } mem_stage_t;

    typedef struct packed {
        logic v;
        tag_t rd;
        logic wen;
    } wb_stage_t;

    // x0 is hard-wired, so a write to it never creates a dependence.
    function automatic logic hz_writes(input logic v, input logic wen, input tag_t rd);
        return v && wen && (rd != '0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the core's controller/datapath and hazard_ctrl.
// HAZARD_PERF_EN adds the stall/flush/freeze performance counters.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwen_i;
    logic              id_is_load_i;
    logic              ex_redirect_i;
    logic              ext_stall_i;

    logic              pc_en_o;
    logic              if_id_en_o;
    logic              if_id_flush_o;
    logic              id_ex_en_o;
    logic              id_ex_flush_o;
    logic              ex_mem_en_o;
    logic              mem_wb_en_o;
    logic [1:0]        fwd_a_sel_o;
    logic [1:0]        fwd_b_sel_o;
    logic              id_bypass_a_o;
    logic              id_bypass_b_o;
    logic [1:0]        state_o;
`ifdef HAZARD_PERF_EN
    logic [31:0]       stall_cnt_o;
    logic [31:0]       flush_cnt_o;
    logic [31:0]       freeze_cnt_o;
`endif

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i,
               id_regwen_i, id_is_load_i, ex_redirect_i, ext_stall_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_en_o, mem_wb_en_o, fwd_a_sel_o, fwd_b_sel_o,
               id_bypass_a_o, id_bypass_b_o, state_o
`ifdef HAZARD_PERF_EN
        , input stall_cnt_o, flush_cnt_o, freeze_cnt_o
`endif
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_rd_i,
               id_regwen_i, id_is_load_i, ex_redirect_i, ext_stall_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
               ex_mem_en_o, mem_wb_en_o, fwd_a_sel_o, fwd_b_sel_o,
               id_bypass_a_o, id_bypass_b_o, state_o
`ifdef HAZARD_PERF_EN
        , output stall_cnt_o, flush_cnt_o, freeze_cnt_o
`endif
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Forwarding compare for one EX operand: picks MEM, then WB, then the register file.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  tag_t       rs,
    input  mem_stage_t mem,
    input  wb_stage_t  wb,
    output fwd_sel_e   sel
);

    // Load data is not ready in MEM; the load-use stall keeps that case from arising.
    always_comb begin
        sel = FWD_REG;
        if (hz_writes(mem.v, mem.wen, mem.rd) && !mem.load && (mem.rd == rs)) begin
            sel = FWD_MEM;
        end else if (hz_writes(wb.v, wb.wen, wb.rd) && (wb.rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush/enable and forwarding.
// HAZARD_PERF_EN adds cycle counters for STALL, redirect and FREEZE.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit RF_WT  = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave hz
);

    function automatic tag_t to_tag(input logic [REG_AW-1:0] a);
        return tag_t'(a);
    endfunction

    tag_t       id_rs1;
    tag_t       id_rs2;
    tag_t       id_rd;
    ex_stage_t  ex_q;
    ex_stage_t  ex_d;
    mem_stage_t mem_q;
    wb_stage_t  wb_q;
    hz_state_e  state_q;
    logic       lu;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       byp_a;
    logic       byp_b;
    fwd_sel_e   fwd_a;
    fwd_sel_e   fwd_b;

    assign id_rs1 = to_tag(hz.id_rs1_i);
    assign id_rs2 = to_tag(hz.id_rs2_i);
    assign id_rd  = to_tag(hz.id_rd_i);

    assign lu = ex_q.load && hz_writes(ex_q.v, ex_q.wen, ex_q.rd) &&
                ((hz.id_use_rs1_i && (id_rs1 == ex_q.rd)) ||
                 (hz.id_use_rs2_i && (id_rs2 == ex_q.rd)));

    // A redirect outranks a load-use stall because the dependent instruction is flushed.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if (hz.ext_stall_i) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (hz.ex_redirect_i) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        ex_d = '0;
        if (!id_ex_flush) begin
            ex_d.v    = 1'b1;
            ex_d.rd   = id_rd;
            ex_d.rs1  = id_rs1;
            ex_d.rs2  = id_rs2;
            ex_d.wen  = hz.id_regwen_i;
            ex_d.load = hz.id_is_load_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!hz.ext_stall_i) begin
            ex_q  <= ex_d;
            mem_q <= '{v: ex_q.v, rd: ex_q.rd, wen: ex_q.wen, load: ex_q.load};
            wb_q  <= '{v: mem_q.v, rd: mem_q.rd, wen: mem_q.wen};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HZ_RUN;
        end else if (hz.ext_stall_i) begin
            state_q <= HZ_FREEZE;
        end else if (hz.ex_redirect_i) begin
            state_q <= HZ_RUN;
        end else if (lu) begin
            state_q <= HZ_STALL;
        end else begin
            state_q <= HZ_RUN;
        end
    end

    hazard_fwd_unit u_fwd_a (
        .rs  (ex_q.rs1),
        .mem (mem_q),
        .wb  (wb_q),
        .sel (fwd_a)
    );

    hazard_fwd_unit u_fwd_b (
        .rs  (ex_q.rs2),
        .mem (mem_q),
        .wb  (wb_q),
        .sel (fwd_b)
    );

    // A write-through register file already returns the WB value in ID.
    generate
        if (RF_WT) begin : g_rf_wt
            assign byp_a = 1'b0;
            assign byp_b = 1'b0;
        end else begin : g_id_bypass
            logic writes_wb;
            assign writes_wb = hz_writes(wb_q.v, wb_q.wen, wb_q.rd);
            assign byp_a = writes_wb && hz.id_use_rs1_i && (wb_q.rd == id_rs1);
            assign byp_b = writes_wb && hz.id_use_rs2_i && (wb_q.rd == id_rs2);
        end
    endgenerate

    assign hz.pc_en_o       = pc_en;
    assign hz.if_id_en_o    = if_id_en;
    assign hz.if_id_flush_o = if_id_flush;
    assign hz.id_ex_en_o    = id_ex_en;
    assign hz.id_ex_flush_o = id_ex_flush;
    assign hz.ex_mem_en_o   = ex_mem_en;
    assign hz.mem_wb_en_o   = mem_wb_en;
    assign hz.fwd_a_sel_o   = fwd_a;
    assign hz.fwd_b_sel_o   = fwd_b;
    assign hz.id_bypass_a_o = byp_a;
    assign hz.id_bypass_b_o = byp_b;
    assign hz.state_o       = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] freeze_cnt_q;

    // Counters keep running through a freeze so FREEZE time is itself measurable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (state_q == HZ_STALL) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (hz.ex_redirect_i && !hz.ext_stall_i) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (state_q == HZ_FREEZE) begin
                freeze_cnt_q <= freeze_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt_o  = stall_cnt_q;
    assign hz.flush_cnt_o  = flush_cnt_q;
    assign hz.freeze_cnt_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-scenario instruction tables, expected
// control vectors queued as each ID instruction is driven and compared at negedge.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if #(.REG_AW(5)) hz_if ();

    hazard_ctrl #(.REG_AW(5), .RF_WT(1'b0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
    } ins_t;

    typedef struct packed {
        ins_t        ins;
        logic        redir;
        logic        stall;
        logic [14:0] vec;
    } step_t;

    typedef struct {
        string       name;
        logic [14:0] vec;
    } exp_t;

    // Control bit order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en
    localparam logic [6:0] C_RUN = 7'b1101011;
    localparam logic [6:0] C_LU  = 7'b0001111;
    localparam logic [6:0] C_RD  = 7'b1111111;
    localparam logic [6:0] C_FRZ = 7'b0000000;
    localparam logic [1:0] F_REG = 2'b00;
    localparam logic [1:0] F_MEM = 2'b01;
    localparam logic [1:0] F_WB  = 2'b10;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_STL = 2'd1;
    localparam logic [1:0] S_FRZ = 2'd2;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic ins_t nop();
        return '0;
    endfunction

    function automatic ins_t alu(int rd, int rs1, int rs2);
        ins_t i = '0;
        i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
        i.u1 = 1'b1; i.u2 = 1'b1; i.wen = 1'b1;
        return i;
    endfunction

    function automatic ins_t alui(int rd, int rs1);
        ins_t i = '0;
        i.rd = 5'(rd); i.rs1 = 5'(rs1); i.u1 = 1'b1; i.wen = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(int rd, int rs1);
        ins_t i = alui(rd, rs1);
        i.ld = 1'b1;
        return i;
    endfunction

    function automatic step_t mk(ins_t i, logic r, logic s, logic [6:0] c,
                                 logic [1:0] fa, logic [1:0] fb,
                                 logic ba, logic bb, logic [1:0] st);
        step_t x;
        x.ins = i; x.redir = r; x.stall = s;
        x.vec = {c, fa, fb, ba, bb, st};
        return x;
    endfunction

    function automatic logic [14:0] observed();
        return {hz_if.pc_en_o, hz_if.if_id_en_o, hz_if.if_id_flush_o, hz_if.id_ex_en_o,
                hz_if.id_ex_flush_o, hz_if.ex_mem_en_o, hz_if.mem_wb_en_o,
                hz_if.fwd_a_sel_o, hz_if.fwd_b_sel_o,
                hz_if.id_bypass_a_o, hz_if.id_bypass_b_o, hz_if.state_o};
    endfunction

    task automatic drive(ins_t i, logic redir, logic stall);
        hz_if.id_rs1_i      = i.rs1;
        hz_if.id_rs2_i      = i.rs2;
        hz_if.id_use_rs1_i  = i.u1;
        hz_if.id_use_rs2_i  = i.u2;
        hz_if.id_rd_i       = i.rd;
        hz_if.id_regwen_i   = i.wen;
        hz_if.id_is_load_i  = i.ld;
        hz_if.ex_redirect_i = redir;
        hz_if.ext_stall_i   = stall;
    endtask

    task automatic do_reset();
        drive(nop(), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(nop(), 1'b0, 1'b0);
        rst = 1'b1;
        sb_q.push_back('{"reset", {C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN}});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e.vec) begin
            errors++;
            $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // lw x5,0(x1); add x6,x5,x2 -> one bubble, then WB forward; WB->ID bypass on x5
    task automatic test_load_use();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(lw(5, 1),     1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(6, 5, 2), 1'b0, 1'b0, C_LU,  F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(6, 5, 2), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_STL));
        s.push_back(mk(alu(9, 3, 5), 1'b0, 1'b0, C_RUN, F_WB,  F_REG, 1'b0, 1'b1, S_RUN));
        s.push_back(mk(nop(),        1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        do_reset();
        foreach (s[k]) begin
            drive(s[k].ins, s[k].redir, s[k].stall);
            sb_q.push_back('{$sformatf("load_use[%0d]", k), s[k].vec});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // add x5,x1,x2; sub x7,x5,x5 -> both operands from MEM, no stall
    task automatic test_alu_fwd();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(alu(5, 1, 2), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(7, 5, 5), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(nop(),        1'b0, 1'b0, C_RUN, F_MEM, F_MEM, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(nop(),        1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        do_reset();
        foreach (s[k]) begin
            drive(s[k].ins, s[k].redir, s[k].stall);
            sb_q.push_back('{$sformatf("alu_fwd[%0d]", k), s[k].vec});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // add x5; nop; or x8,x5,x3 -> WB forward; then x5 in MEM and WB -> MEM wins
    task automatic test_wb_fwd();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(alu(5, 1, 2), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(nop(),        1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(8, 5, 3), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(nop(),        1'b0, 1'b0, C_RUN, F_WB,  F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(5, 1, 2), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(5, 6, 7), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(9, 5, 5), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alui(10, 5),  1'b0, 1'b0, C_RUN, F_MEM, F_MEM, 1'b1, 1'b0, S_RUN));
        do_reset();
        foreach (s[k]) begin
            drive(s[k].ins, s[k].redir, s[k].stall);
            sb_q.push_back('{$sformatf("wb_fwd[%0d]", k), s[k].vec});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // writes to x0 never forward, bypass or stall (including lw x0 followed by a use)
    task automatic test_x0();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(alui(0, 0),   1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(4, 0, 0), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(lw(0, 0),     1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(4, 0, 0), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(nop(),        1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        do_reset();
        foreach (s[k]) begin
            drive(s[k].ins, s[k].redir, s[k].stall);
            sb_q.push_back('{$sformatf("x0[%0d]", k), s[k].vec});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // redirect cancels a coincident load-use; redirect during freeze waits for release
    task automatic test_redirect_lu();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(lw(5, 1),     1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(6, 5, 2), 1'b1, 1'b0, C_RD,  F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(nop(),        1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(nop(),        1'b1, 1'b1, C_FRZ, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(nop(),        1'b1, 1'b0, C_RD,  F_REG, F_REG, 1'b0, 1'b0, S_FRZ));
        s.push_back(mk(nop(),        1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        do_reset();
        foreach (s[k]) begin
            drive(s[k].ins, s[k].redir, s[k].stall);
            sb_q.push_back('{$sformatf("redirect_lu[%0d]", k), s[k].vec});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // three-cycle freeze over a load-use, bubble after release, then async reset mid-stream
    task automatic test_freeze();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(lw(5, 1),      1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(6, 5, 2),  1'b0, 1'b1, C_FRZ, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(6, 5, 2),  1'b0, 1'b1, C_FRZ, F_REG, F_REG, 1'b0, 1'b0, S_FRZ));
        s.push_back(mk(alu(6, 5, 2),  1'b0, 1'b1, C_FRZ, F_REG, F_REG, 1'b0, 1'b0, S_FRZ));
        s.push_back(mk(alu(6, 5, 2),  1'b0, 1'b0, C_LU,  F_REG, F_REG, 1'b0, 1'b0, S_FRZ));
        s.push_back(mk(alu(6, 5, 2),  1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_STL));
        s.push_back(mk(nop(),         1'b0, 1'b0, C_RUN, F_WB,  F_REG, 1'b0, 1'b0, S_RUN));
        s.push_back(mk(alu(12, 6, 6), 1'b0, 1'b0, C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN));
        do_reset();
        foreach (s[k]) begin
            drive(s[k].ins, s[k].redir, s[k].stall);
            sb_q.push_back('{$sformatf("freeze[%0d]", k), s[k].vec});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
            end
            @(posedge clk);
            #1;
        end
        drive(nop(), 1'b0, 1'b0);
        sb_q.push_back('{"pre_reset_fwd", {C_RUN, F_WB, F_WB, 1'b0, 1'b0, S_RUN}});
        #1;
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e.vec) begin
            errors++;
            $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
        end
        rst = 1'b1;
        sb_q.push_back('{"mid_reset", {C_RUN, F_REG, F_REG, 1'b0, 1'b0, S_RUN}});
        #1;
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e.vec) begin
            errors++;
            $display("[TB] FAIL %s: got=%b expected=%b", e.name, observed(), e.vec);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        drive(nop(), 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_wb_fwd();
        test_x0();
        test_redirect_lu();
        test_freeze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Generates enable/flush for PC and the four pipeline registers, and forwarding selects for the EX-stage operand muxes.
- Keeps its own shadow pipeline of destination/source register tags, advanced in lock-step with the datapath using the controls it issues.
- Sits beside the main controller and takes decoded ID-stage fields, the taken-redirect from EX and a wait from the LSU.

Parameters:
- REG_AW, 5, register-address width.
- RF_WT, 1, 1 = register file writes through in the same cycle, so no WB→ID bypass is driven; 0 = drive id_bypass_a_o/b_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- id_rs1_i  in  REG_AW  rs1 of the instruction in ID
- id_rs2_i  in  REG_AW  rs2 of the instruction in ID
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- id_rd_i  in  REG_AW  rd of the instruction in ID
- id_regwen_i  in  1  ID instruction writes rd
- id_is_load_i  in  1  ID instruction is a load
- ex_redirect_i  in  1  taken branch/jump in EX (PCSel_EX)
- ext_stall_i  in  1  LSU/MMIO wait; freeze the whole pipeline
- pc_en_o  out  1  PC load enable
- if_id_en_o  out  1  IF/ID register enable
- if_id_flush_o  out  1  IF/ID loads a bubble (NOP, regwen=0)
- id_ex_en_o  out  1  ID/EX register enable
- id_ex_flush_o  out  1  ID/EX loads a bubble
- ex_mem_en_o  out  1  EX/MEM register enable
- mem_wb_en_o  out  1  MEM/WB register enable
- fwd_a_sel_o  out  2  EX operand A source: 00 = reg, 01 = MEM alu, 10 = WB result
- fwd_b_sel_o  out  2  same, for operand B / store data
- id_bypass_a_o  out  1  ID rs1 takes the WB value (RF_WT=0 only, else 0)
- id_bypass_b_o  out  1  ID rs2 takes the WB value
- state_o  out  2  FSM state: 0 RUN, 1 STALL, 2 FREEZE

Behaviour:
- Shadow regs per stage: EX {v, rd, rs1, rs2, wen, load}; MEM {v, rd, wen, load}; WB {v, rd, wen}. On reset all are cleared, FSM = RUN.
- Reset output values: all enables 1, flushes 0, fwd selects 00, bypasses 0, state_o 0.
- "writes(x)" = v && wen && rd != 0. Register x0 is never a hazard and is never forwarded.
- Load-use hazard (lu): EX.load && writes(EX) && ((id_use_rs1_i && id_rs1_i == EX.rd) || (id_use_rs2_i && id_rs2_i == EX.rd)).
- Control outputs are combinational. Priority, highest first:
  1. ext_stall_i: every enable 0, flushes 0, shadow regs hold, state becomes FREEZE. A redirect during freeze is held by the datapath and acted on after release.
  2. ex_redirect_i: if_id_flush_o = id_ex_flush_o = 1, all enables 1, shadow EX gets a bubble (v=0). A coincident lu is cancelled, since the consumer is flushed.
  3. lu: pc_en_o = if_id_en_o = 0, id_ex_flush_o = 1, EX/MEM and MEM/WB advance, shadow EX gets a bubble, state becomes STALL.
  4. Otherwise RUN: all advance.
- Shadow advance: EX ← ID fields with v=1, or a bubble when id_ex_flush_o; MEM ← EX; WB ← MEM.
- FSM:
  - RUN → STALL on lu. STALL → RUN next cycle; lu is guaranteed clear once the load reaches MEM.
  - Any state → FREEZE on ext_stall_i. FREEZE → RUN on release, re-evaluating lu and redirect that cycle.
- Forwarding, per operand using EX.rs1/EX.rs2:
  - 01 if writes(MEM) && !MEM.load && MEM.rd matches.
  - else 10 if writes(WB) && WB.rd matches.
  - else 00.
  - MEM has priority over WB. A load in MEM is never forwarded; the lu stall guarantees this case does not arise.
- id_bypass (RF_WT=0): writes(WB) && WB.rd == id_rsN_i && id_use_rsN_i.
- Latency: one bubble per load-use, two flushed slots per taken redirect, zero for ALU→ALU dependences.
- Reset mid-operation: all shadow state is invalid immediately, so no forwarding occurs until new instructions flow.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs stall_cnt_o[31:0] (cycles in STALL), flush_cnt_o[31:0] (redirect cycles) and freeze_cnt_o[31:0] (cycles in FREEZE).
  - Counters wrap modulo 2^32, clear on rst_i, and freeze_cnt counts even while frozen.
- Undefined: the ports and counters are absent.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e {FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10};
  - hz_state_e {HZ_RUN, HZ_STALL, HZ_FREEZE};
  - the shadow-stage struct typedefs.
- One sub-module, hazard_fwd_unit: the combinational forwarding compare, instantiated once per operand.

Test Plan:
- "lw x5,0(x1); add x6,x5,x2" → one cycle with pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, state_o=1; then add in EX with fwd_a_sel_o=10.
- "add x5,x1,x2; sub x7,x5,x5" → fwd_a_sel_o=fwd_b_sel_o=01, no stall.
- "add x5…; nop; or x8,x5,x3" → fwd_a_sel_o=10; with add x5 in both MEM and WB, MEM (01) wins.
- "addi x0,x0,1; add x4,x0,x0" → fwd selects stay 00.
- Taken beq in EX coincident with lu in ID → if_id_flush_o=id_ex_flush_o=1, pc_en_o=1, no STALL entry.
- ext_stall_i high 3 cycles during a lu → all enables 0 and state_o=2 for 3 cycles; stall bubble issued after release; rst_i pulse mid-stream clears all fwd selects to 00.
